load_from_bram: RTL and testbench

LOAD_FROM_BRAM -- requirements
Module: load_from_bram

---
 rtl/load_from_bram_pkg.sv | 26 ++
 rtl/load_from_bram_if.sv | 36 +++
 rtl/load_addr_gen.sv | 36 +++
 rtl/load_from_bram.sv | 158 +++++++++++++++
 tb/tb_load_from_bram.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/load_from_bram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : load_from_bram_pkg
// Brief    : Shared sizing defaults and FSM state encoding for load_from_bram.
// Revision : 1.0 - initial release
// ============================================================================
package load_from_bram_pkg;

    localparam int NUM_CH = 8;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DRAIN   = 2'd2,
        PRESENT = 2'd3
    } state_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_from_bram_if.sv
`default_nettype none
// ============================================================================
// Module   : load_from_bram_if
// Brief    : Control, BRAM read port and beat stream of the BRAM loader.
// Revision : 1.0 - initial release
// ============================================================================
interface load_from_bram_if #(
    parameter int NUM_CH = load_from_bram_pkg::NUM_CH,
    parameter int ADDR_W = load_from_bram_pkg::ADDR_W,
    parameter int DATA_W = load_from_bram_pkg::DATA_W,
    parameter int LEN_W  = load_from_bram_pkg::LEN_W
);
    logic                     start;
    logic [NUM_CH*ADDR_W-1:0] starting_addr;
    logic [LEN_W-1:0]         num_words;
    logic                     bram_en;
    logic [ADDR_W-1:0]        bram_addr;
    logic [DATA_W-1:0]        bram_rdata;
    logic [NUM_CH*DATA_W-1:0] data_o;
    logic                     data_o_valid;
    logic                     data_o_ready;
    logic                     busy;
    logic                     done;

    // master: the loader itself; slave: the surrounding system
    modport master (
        input  start, starting_addr, num_words, bram_rdata, data_o_ready,
        output bram_en, bram_addr, data_o, data_o_valid, busy, done
    );

    modport slave (
        output start, starting_addr, num_words, bram_rdata, data_o_ready,
        input  bram_en, bram_addr, data_o, data_o_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/load_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : load_addr_gen
// Brief    : Picks one channel base address, adds the beat index, registers it.
// Revision : 1.0 - initial release
// ============================================================================
module load_addr_gen #(
    parameter int NUM_CH = 8,
    parameter int ADDR_W = 18,
    parameter int LEN_W  = 8,
    parameter int CH_W   = 3
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     load,
    input  wire logic [NUM_CH*ADDR_W-1:0] base,
    input  wire logic [CH_W-1:0]          sel,
    input  wire logic [LEN_W-1:0]         k,
    output logic      [ADDR_W-1:0]        addr
);
    logic [ADDR_W-1:0] w_sel_base;
    logic [ADDR_W-1:0] w_sum;

    assign w_sel_base = base[sel*ADDR_W +: ADDR_W];
    // ADDR_W-wide add: addresses wrap modulo 2^ADDR_W
    assign w_sum      = w_sel_base + ADDR_W'(k);

    always_ff @(posedge clk) begin
        if (reset) begin
            addr <= '0;
        end else if (load) begin
            addr <= w_sum;
        end
    end
endmodule
`default_nettype wire

// File: rtl/load_from_bram.sv
`default_nettype none
// ============================================================================
// Module   : load_from_bram
// Brief    : Reads one word per channel from BRAM per beat and presents the
//            assembled beat on a valid/ready stream, num_words beats in total.
// Revision : 1.0 - initial release
// ============================================================================
module load_from_bram #(
    parameter int NUM_CH = load_from_bram_pkg::NUM_CH,
    parameter int ADDR_W = load_from_bram_pkg::ADDR_W,
    parameter int DATA_W = load_from_bram_pkg::DATA_W,
    parameter int LEN_W  = load_from_bram_pkg::LEN_W
) (
    input  wire logic         clk,
    input  wire logic         reset,
    load_from_bram_if.master  bus
);
    import load_from_bram_pkg::*;

    localparam int              CH_W      = ch_width(NUM_CH);
    localparam logic [CH_W-1:0] C_LAST_CH = CH_W'(NUM_CH - 1);

    state_t                   r_state, w_state_nxt;
    logic [CH_W-1:0]          r_ch, w_ch_nxt;
    logic [LEN_W-1:0]         r_k, w_k_nxt;
    logic [LEN_W-1:0]         r_num_words;
    logic [NUM_CH*ADDR_W-1:0] r_base;
    logic [NUM_CH*DATA_W-1:0] r_beat;
    logic                     r_rd_pend;
    logic [CH_W-1:0]          r_rd_ch;
    logic                     r_done, w_done_nxt;

    logic                     w_accept;
    logic                     w_addr_load;
    logic                     w_addr_live;
    logic [CH_W-1:0]          w_addr_sel;
    logic [LEN_W-1:0]         w_addr_k;
    logic [LEN_W:0]           w_k_inc;
    logic [NUM_CH*ADDR_W-1:0] w_addr_base;
    logic [ADDR_W-1:0]        w_bram_addr;

    assign w_accept    = (r_state == IDLE) && bus.start;
    assign w_k_inc     = {1'b0, r_k} + {{LEN_W{1'b0}}, 1'b1};
    // The first address is formed in the accept cycle, before r_base is loaded
    assign w_addr_base = w_addr_live ? bus.starting_addr : r_base;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ch        <= '0;
            r_k         <= '0;
            r_num_words <= '0;
            r_base      <= '0;
            r_done      <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_rd_ch     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ch      <= w_ch_nxt;
            r_k       <= w_k_nxt;
            r_done    <= w_done_nxt;
            r_rd_pend <= (r_state == FETCH);
            r_rd_ch   <= r_ch;
            if (w_accept) begin
                r_base      <= bus.starting_addr;
                r_num_words <= bus.num_words;
            end
        end
    end

    // Read data arrives one cycle after its request; steer it to its channel slot
    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat <= '0;
        end else if (r_rd_pend) begin
            r_beat[r_rd_ch*DATA_W +: DATA_W] <= bus.bram_rdata;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_k_nxt     = r_k;
        w_done_nxt  = 1'b0;
        w_addr_load = 1'b0;
        w_addr_live = 1'b0;
        w_addr_sel  = '0;
        w_addr_k    = r_k;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.num_words == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = FETCH;
                        w_ch_nxt    = '0;
                        w_k_nxt     = '0;
                        w_addr_load = 1'b1;
                        w_addr_live = 1'b1;
                        w_addr_k    = '0;
                    end
                end
            end
            FETCH: begin
                if (r_ch == C_LAST_CH) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_ch_nxt    = r_ch + CH_W'(1);
                    w_addr_load = 1'b1;
                    w_addr_sel  = r_ch + CH_W'(1);
                end
            end
            DRAIN: begin
                w_state_nxt = PRESENT;
            end
            PRESENT: begin
                if (bus.data_o_ready) begin
                    w_k_nxt = w_k_inc[LEN_W-1:0];
                    if (w_k_inc < {1'b0, r_num_words}) begin
                        w_state_nxt = FETCH;
                        w_ch_nxt    = '0;
                        w_addr_load = 1'b1;
                        w_addr_k    = w_k_inc[LEN_W-1:0];
                    end else begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    load_addr_gen #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W),
        .CH_W   (CH_W)
    ) u_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .load   (w_addr_load),
        .base   (w_addr_base),
        .sel    (w_addr_sel),
        .k      (w_addr_k),
        .addr   (w_bram_addr)
    );

    assign bus.bram_en      = (r_state == FETCH);
    assign bus.bram_addr    = w_bram_addr;
    assign bus.data_o       = r_beat;
    assign bus.data_o_valid = (r_state == PRESENT);
    assign bus.busy         = (r_state != IDLE);
    assign bus.done         = r_done;
endmodule
`default_nettype wire

// File: tb/tb_load_from_bram.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_from_bram
// Brief    : Directed self-checking bench for load_from_bram.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_from_bram;

    logic clk = 1'b0;
    logic reset;

    load_from_bram_if bus ();

    load_from_bram dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // BRAM model: mem[a] = a mod 256, one-cycle read latency
    always @(posedge clk) begin
        if (bus.bram_en) bus.bram_rdata <= bus.bram_addr[7:0];
    end

    int n_tests = 0;
    int n_fail  = 0;
    int base [8];
    int beats;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic set_bases();
        for (int n = 0; n < 8; n++) bus.starting_addr[n*18 +: 18] = 18'(base[n]);
    endtask

    function automatic logic [63:0] exp_beat(input int k);
        logic [63:0] r;
        int a;
        r = '0;
        for (int n = 0; n < 8; n++) begin
            a = (base[n] + k) % 262144;
            r[n*8 +: 8] = 8'(a % 256);
        end
        return r;
    endfunction

    // Issue start in the current cycle; returns at cycle 1
    task automatic start_read(input int nw);
        bus.num_words = 8'(nw);
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input int first_k, output int nbeats);
        int  k;
        bit  got;
        k      = first_k;
        nbeats = 0;
        got    = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            if (bus.data_o_valid && bus.data_o_ready) begin
                check("beat_data", bus.data_o, exp_beat(k));
                k++;
                nbeats++;
            end
            if (bus.done) got = 1'b1;
            else          tick();
        end
        check("done_seen", 64'(got), 64'd1);
    endtask

    initial begin
        for (int n = 0; n < 8; n++) base[n] = 1000 * n;
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.num_words    = 8'd1;
        bus.data_o_ready = 1'b1;
        bus.starting_addr = '0;
        set_bases();

        // reset, with a start asserted alongside it
        tick();
        bus.start = 1'b1;
        tick();
        check("rst_bram_en", 64'(bus.bram_en), 64'd0);
        check("rst_bram_addr", 64'(bus.bram_addr), 64'd0);
        check("rst_valid", 64'(bus.data_o_valid), 64'd0);
        check("rst_data", bus.data_o, 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        reset     = 1'b0;
        bus.start = 1'b0;
        tick();
        check("start_with_reset_ignored", 64'(bus.busy), 64'd0);

        // single beat
        start_read(1);
        for (int c = 1; c <= 8; c++) begin
            check("single_fetch_en", 64'(bus.bram_en), 64'd1);
            check("single_fetch_addr", 64'(bus.bram_addr), 64'(base[c-1]));
            tick();
        end
        check("single_drain_en", 64'(bus.bram_en), 64'd0);
        check("single_drain_valid", 64'(bus.data_o_valid), 64'd0);
        tick();
        check("single_valid_c10", 64'(bus.data_o_valid), 64'd1);
        check("single_data", bus.data_o, 64'h587088A0B8D0E800);
        tick();
        check("single_done_c11", 64'(bus.done), 64'd1);
        check("single_busy_c11", 64'(bus.busy), 64'd0);
        check("single_valid_c11", 64'(bus.data_o_valid), 64'd0);
        tick();
        check("single_done_pulse", 64'(bus.done), 64'd0);

        // full read-out, 32 beats
        start_read(32);
        run_until_done(32 * 11 + 20, 0, beats);
        check("full_beats", 64'(beats), 64'd32);
        tick();
        check("full_done_pulse", 64'(bus.done), 64'd0);
        check("full_idle", 64'(bus.busy), 64'd0);

        // backpressure: ready low for 5 cycles after valid
        bus.data_o_ready = 1'b0;
        start_read(1);
        repeat (9) tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(bus.data_o_valid), 64'd1);
            check("bp_data_stable", bus.data_o, exp_beat(0));
            check("bp_no_reads", 64'(bus.bram_en), 64'd0);
            tick();
        end
        check("bp_valid_before_xfer", 64'(bus.data_o_valid), 64'd1);
        bus.data_o_ready = 1'b1;
        tick();
        check("bp_done", 64'(bus.done), 64'd1);
        check("bp_valid_dropped", 64'(bus.data_o_valid), 64'd0);

        // address wrap on channel 0
        base[0] = 262143;
        set_bases();
        start_read(2);
        check("wrap_addr_k0", 64'(bus.bram_addr), 64'd262143);
        repeat (9) tick();
        check("wrap_beat0_ch0", 64'(bus.data_o[7:0]), 64'hFF);
        tick();
        check("wrap_fetch_en", 64'(bus.bram_en), 64'd1);
        check("wrap_addr_k1", 64'(bus.bram_addr), 64'd0);
        run_until_done(40, 1, beats);
        check("wrap_beats", 64'(beats), 64'd1);
        tick();
        base[0] = 0;
        set_bases();

        // zero length
        start_read(0);
        check("zero_done_c1", 64'(bus.done), 64'd1);
        check("zero_no_read", 64'(bus.bram_en), 64'd0);
        check("zero_busy", 64'(bus.busy), 64'd0);
        tick();
        check("zero_done_pulse", 64'(bus.done), 64'd0);
        check("zero_no_read_after", 64'(bus.bram_en), 64'd0);

        // start while busy is ignored
        start_read(1);
        tick();
        tick();
        bus.start     = 1'b1;
        bus.num_words = 8'd5;
        tick();
        bus.start     = 1'b0;
        bus.num_words = 8'd1;
        run_until_done(40, 0, beats);
        check("busy_start_beats", 64'(beats), 64'd1);
        tick();
        check("busy_start_idle", 64'(bus.busy), 64'd0);

        // reset during FETCH, then a normal run
        start_read(1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("midrst_bram_en", 64'(bus.bram_en), 64'd0);
        check("midrst_bram_addr", 64'(bus.bram_addr), 64'd0);
        check("midrst_valid", 64'(bus.data_o_valid), 64'd0);
        check("midrst_data", bus.data_o, 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        reset = 1'b0;
        start_read(1);
        check("post_rst_addr", 64'(bus.bram_addr), 64'd0);
        check("post_rst_en", 64'(bus.bram_en), 64'd1);
        run_until_done(40, 0, beats);
        check("post_rst_beats", 64'(beats), 64'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
